// File: rtl/boot_pkg.sv
// Shared types and defaults for the UART boot loader and its MMIO status readback.
// Pure declarations: no logic, no latency, no flow control.
package boot_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LEN   = 3'd1,
        DATA  = 3'd2,
        WRITE = 3'd3,
        CSUM  = 3'd4,
        DONE  = 3'd5,
        ERR   = 3'd6
    } boot_state_t;

    localparam logic [7:0]  BOOT_SYNC_BYTE   = 8'hA5;
    localparam int          BOOT_MAX_WORDS   = 4096;
    localparam logic [31:0] BOOT_STATUS_ADDR = 32'h0000_FF00;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/boot_byte_assembler.sv
// Little-endian 4-byte collector shared by the length and data phases.
// word_o includes the byte pushed this cycle; full_o flags the 4th push, no stall path.
module boot_byte_assembler (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clr_i,
    input  logic        push_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        full_o
);

    logic [1:0]  cnt_q;
    logic [23:0] word_q;

    // Newest byte lands on top so the first byte received ends up in [7:0].
    assign word_o = {byte_i, word_q};
    assign full_o = push_i && (cnt_q == 2'd3);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= 2'd0;
            word_q <= 24'd0;
        end else if (clr_i) begin
            cnt_q  <= 2'd0;
        end else if (push_i) begin
            cnt_q  <= cnt_q + 2'd1;
            word_q <= word_o[31:8];
        end
    end

endmodule

// File: rtl/uart_boot_loader.sv
// Parses sync/length/data/checksum frames from the UART RX FIFO into instruction-memory writes.
// One byte popped per cycle at most; a write is held while mem_hold_i is high.
module uart_boot_loader
    import boot_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter logic [7:0]  SYNC_BYTE   = BOOT_SYNC_BYTE,
    parameter int          MAX_WORDS   = BOOT_MAX_WORDS,
    parameter int          TIMEOUT_CYC = 5_000_000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        boot_en_i,
    input  logic        rx_data_present_i,
    input  logic [7:0]  uart_dout_i,
    output logic        rx_ren_o,
    input  logic        mem_hold_i,
    output logic        imem_prog_ena_o,
    output logic        imem_en_o,
    output logic [31:0] imem_addr_o,
    output logic [31:0] imem_din_o,
    output logic        prog_active_o,
    output logic        done_o,
    output logic        err_o,
    output logic [15:0] words_written_o
);

    if (MAX_WORDS < 1 || MAX_WORDS > 65535) begin : g_max_words_bad
        $error("uart_boot_loader: MAX_WORDS must be within 1..65535");
    end

    boot_state_t state_q, state_d;
    logic [31:0] len_q, len_d;
    logic [31:0] din_q, din_d;
    logic [31:0] tmo_q, tmo_d;
    logic [15:0] words_q, words_d;
    logic [7:0]  csum_q, csum_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic        in_frame, pop, tmo_hit, asm_full;
    logic [31:0] asm_word;

    assign in_frame = (state_q == LEN) || (state_q == DATA) || (state_q == CSUM);
    // Reset gates the pop so a FIFO held non-empty is not drained while in reset.
    assign pop      = rst_ni && boot_en_i && rx_data_present_i && (in_frame || state_q == IDLE);
    assign tmo_hit  = in_frame && !pop && ((tmo_q + 32'd1) == 32'(TIMEOUT_CYC));

    boot_byte_assembler u_asm (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (!in_frame && state_q != WRITE),
        .push_i (pop && (state_q == LEN || state_q == DATA)),
        .byte_i (uart_dout_i),
        .word_o (asm_word),
        .full_o (asm_full)
    );

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        din_d   = din_q;
        words_d = words_q;
        csum_d  = csum_q;
        done_d  = done_q;
        err_d   = err_q;
        tmo_d   = tmo_q;

        if (pop || !in_frame && state_q != WRITE) begin
            tmo_d = 32'd0;
        end else if (in_frame) begin
            tmo_d = tmo_q + 32'd1;
        end

        case (state_q)
            IDLE: begin
                if (pop && uart_dout_i == SYNC_BYTE) begin
                    state_d = LEN;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    words_d = 16'd0;
                    csum_d  = 8'd0;
                end
            end
            LEN: begin
                if (!boot_en_i || tmo_hit) begin
                    state_d = ERR;
                end else if (asm_full) begin
                    len_d = asm_word;
                    if (asm_word > 32'(MAX_WORDS)) state_d = ERR;
                    else if (asm_word == 32'd0)    state_d = CSUM;
                    else                           state_d = DATA;
                end
            end
            DATA: begin
                if (!boot_en_i || tmo_hit) begin
                    state_d = ERR;
                end else if (pop) begin
                    csum_d = csum_q + uart_dout_i;
                    if (asm_full) begin
                        din_d   = asm_word;
                        state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                if (!boot_en_i) begin
                    state_d = ERR;
                end else if (!mem_hold_i) begin
                    words_d = sat_inc16(words_q);
                    state_d = (({16'd0, words_q} + 32'd1) == len_q) ? CSUM : DATA;
                end
            end
            CSUM: begin
                if (!boot_en_i || tmo_hit) begin
                    state_d = ERR;
                end else if (pop) begin
                    state_d = (uart_dout_i == csum_q) ? DONE : ERR;
                end
            end
            // Hand any waiting byte to IDLE, which discards it or starts a new frame.
            DONE, ERR: begin
                if (!boot_en_i || rx_data_present_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (state_d == DONE) done_d = 1'b1;
        if (state_d == ERR)  err_d  = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            len_q   <= 32'd0;
            din_q   <= 32'd0;
            tmo_q   <= 32'd0;
            words_q <= 16'd0;
            csum_q  <= 8'd0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            din_q   <= din_d;
            tmo_q   <= tmo_d;
            words_q <= words_d;
            csum_q  <= csum_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign rx_ren_o        = pop;
    assign imem_prog_ena_o = (state_q == WRITE) && boot_en_i;
    assign imem_en_o       = imem_prog_ena_o;
    assign imem_addr_o     = BASE_ADDR + {14'd0, words_q, 2'b00};
    assign imem_din_o      = din_q;
    assign prog_active_o   = in_frame || (state_q == WRITE);
    assign done_o          = done_q;
    assign err_o           = err_q;
    assign words_written_o = words_q;

endmodule

// File: tb/tb_uart_boot_loader.sv
// Randomized frame traffic through a modelled RX FIFO, checked against a frame-level parser model.
module tb_uart_boot_loader;

    localparam int          MAXW = 4096;
    localparam logic [31:0] BASE = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n, boot_en, rx_data_present, rx_ren, mem_hold;
    logic        imem_prog_ena, imem_en, prog_active, done, err;
    logic [7:0]  uart_dout;
    logic [31:0] imem_addr, imem_din;
    logic [15:0] words_written;

    always #5 clk = ~clk;

    uart_boot_loader #(
        .BASE_ADDR   (BASE),
        .SYNC_BYTE   (8'hA5),
        .MAX_WORDS   (MAXW),
        .TIMEOUT_CYC (100)
    ) dut (
        .clk_i             (clk),
        .rst_ni            (rst_n),
        .boot_en_i         (boot_en),
        .rx_data_present_i (rx_data_present),
        .uart_dout_i       (uart_dout),
        .rx_ren_o          (rx_ren),
        .mem_hold_i        (mem_hold),
        .imem_prog_ena_o   (imem_prog_ena),
        .imem_en_o         (imem_en),
        .imem_addr_o       (imem_addr),
        .imem_din_o        (imem_din),
        .prog_active_o     (prog_active),
        .done_o            (done),
        .err_o             (err),
        .words_written_o   (words_written)
    );

    int n_chk = 0;
    int n_fail = 0;

    logic [7:0]  q[$];
    logic [7:0]  frm[$];
    logic [31:0] cap_a[$], cap_d[$], exp_wa[$], exp_wd[$];
    bit          pend_pop, gaps, rand_hold, err_prev, exp_done, exp_err;
    int          hold_left, since_pop, err_rise_k, strobes, pre_strobes;
    int          stable_bad, en_bad, act_bad, exp_words;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] cap_at(input int k);
        return (k < cap_d.size()) ? cap_d[k] : 32'hDEAD_BEEF;
    endfunction

    // One clock: retire last cycle's pop, drive the FIFO head, then observe the DUT.
    task automatic tick();
        logic [7:0] tmpb;
        @(negedge clk);
        if (pend_pop) begin
            if (q.size() > 0) tmpb = q.pop_front();
            since_pop = 0;
        end else begin
            since_pop++;
        end
        rx_data_present = (q.size() > 0) && (!gaps || $urandom_range(3) != 0);
        uart_dout       = (q.size() > 0) ? q[0] : 8'h00;
        mem_hold        = rand_hold ? ($urandom_range(2) == 0) : (hold_left > 0);
        #1;
        pend_pop = rx_ren;
        if (imem_en !== imem_prog_ena) en_bad++;
        if (imem_prog_ena) begin
            strobes++;
            if (cap_a.size() == 0) begin
                pre_strobes++;
                if (exp_wa.size() == 0 || imem_addr !== exp_wa[0] || imem_din !== exp_wd[0])
                    stable_bad++;
            end
            if (mem_hold) begin
                if (hold_left > 0) hold_left--;
            end else begin
                cap_a.push_back(imem_addr);
                cap_d.push_back(imem_din);
                if (!prog_active) act_bad++;
            end
        end
        if (err && !err_prev) err_rise_k = since_pop;
        err_prev = err;
    endtask

    // Frame-level reference: find sync, read LE length, then words and a mod-256 byte sum.
    task automatic model_frame();
        int          i;
        logic [31:0] n, w;
        logic [7:0]  sum;
        exp_wa.delete(); exp_wd.delete();
        exp_words = 0; exp_done = 0; exp_err = 1;
        i = 0;
        while (i < frm.size() && frm[i] != 8'hA5) i++;
        i++;
        if (i + 4 > frm.size()) return;
        n = {frm[i+3], frm[i+2], frm[i+1], frm[i]};
        i += 4;
        if (n > MAXW) return;
        sum = 8'd0;
        for (int k = 0; k < int'(n); k++) begin
            if (i + 4 > frm.size()) return;
            w   = {frm[i+3], frm[i+2], frm[i+1], frm[i]};
            sum = sum + frm[i] + frm[i+1] + frm[i+2] + frm[i+3];
            exp_wa.push_back(BASE + 32'(4 * k));
            exp_wd.push_back(w);
            exp_words++;
            i += 4;
        end
        if (i >= frm.size()) return;
        exp_err  = (frm[i] != sum);
        exp_done = !exp_err;
    endtask

    task automatic build_frame(input logic [31:0] len, input int nwords, input bit bad_sum, input int garbage);
        logic [7:0] b, sum;
        frm.delete();
        sum = 8'd0;
        for (int k = 0; k < garbage; k++) begin
            b = 8'($urandom_range(255));
            frm.push_back((b == 8'hA5) ? 8'h00 : b);
        end
        frm.push_back(8'hA5);
        for (int k = 0; k < 4; k++) frm.push_back(len[8*k +: 8]);
        for (int k = 0; k < 4 * nwords; k++) begin
            b = 8'($urandom_range(255));
            frm.push_back(b);
            sum = sum + b;
        end
        frm.push_back(bad_sum ? sum + 8'd1 : sum);
    endtask

    task automatic run_frame(input string tag, input bit rhold, input int hold, input bit gp);
        bit fin;
        model_frame();
        rand_hold = rhold; hold_left = hold; gaps = gp;
        cap_a.delete(); cap_d.delete();
        strobes = 0; pre_strobes = 0; stable_bad = 0; en_bad = 0; act_bad = 0; err_rise_k = -1;
        foreach (frm[k]) q.push_back(frm[k]);
        fin = 0;
        for (int k = 0; k < 4000; k++) begin
            tick();
            if (q.size() == 0 && !pend_pop && !prog_active) begin
                fin = 1;
                break;
            end
        end
        repeat (2) tick();
        chk({tag, "/settle"}, 32'(fin), 32'd1);
        chk({tag, "/done"}, 32'(done), 32'(exp_done));
        chk({tag, "/err"}, 32'(err), 32'(exp_err));
        chk({tag, "/words"}, 32'(words_written), 32'(exp_words));
        chk({tag, "/nwrites"}, 32'(cap_a.size()), 32'(exp_wa.size()));
        for (int k = 0; k < cap_a.size() && k < exp_wa.size(); k++) begin
            chk({tag, "/waddr"}, cap_a[k], exp_wa[k]);
            chk({tag, "/wdata"}, cap_d[k], exp_wd[k]);
        end
        chk({tag, "/en_eq_prog"}, 32'(en_bad), 32'd0);
        chk({tag, "/active_at_commit"}, 32'(act_bad), 32'd0);
        chk({tag, "/active_after"}, 32'(prog_active), 32'd0);
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "/rx_ren"}, 32'(rx_ren), 32'd0);
        chk({tag, "/prog_active"}, 32'(prog_active), 32'd0);
        chk({tag, "/prog_ena"}, 32'(imem_prog_ena), 32'd0);
        chk({tag, "/imem_en"}, 32'(imem_en), 32'd0);
        chk({tag, "/done"}, 32'(done), 32'd0);
        chk({tag, "/err"}, 32'(err), 32'd0);
        chk({tag, "/words"}, 32'(words_written), 32'd0);
        chk({tag, "/addr"}, imem_addr, BASE);
        chk({tag, "/din"}, imem_din, 32'd0);
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int kind, nw, g, keep;
        bit fin;
        rst_n = 1'b0; boot_en = 1'b1; rx_data_present = 1'b0; uart_dout = 8'h00; mem_hold = 1'b0;
        pend_pop = 0; gaps = 0; rand_hold = 0; hold_left = 0; since_pop = 0; err_prev = 0;
        repeat (3) tick();
        chk_cleared("reset");
        rst_n = 1'b1;
        repeat (2) tick();

        // 0x11+0x22+...+0x88 = 0x264, so the good checksum byte is 0x64.
        frm = '{8'hA5, 8'h02, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
                8'h55, 8'h66, 8'h77, 8'h88, 8'h64};
        run_frame("nominal", 0, 0, 0);
        chk("nominal/w0", cap_at(0), 32'h4433_2211);
        chk("nominal/w1", cap_at(1), 32'h8877_6655);

        frm[13] = 8'h65;
        run_frame("badsum", 0, 0, 0);

        frm = '{8'hA5, 8'h01, 8'h10, 8'h00, 8'h00};
        run_frame("oversize", 0, 0, 0);
        chk("oversize/err_latency", 32'(err_rise_k), 32'd0);
        chk("oversize/strobes", 32'(strobes), 32'd0);

        frm = '{8'hA5, 8'h02, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
                8'h55, 8'h66, 8'h77, 8'h88, 8'h64};
        run_frame("backpressure", 0, 5, 0);
        chk("backpressure/first_strobe_cycles", 32'(pre_strobes), 32'd6);
        chk("backpressure/stable", 32'(stable_bad), 32'd0);
        chk("backpressure/strobes", 32'(strobes), 32'd7);

        frm = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h00, 8'h11};
        run_frame("timeout", 0, 0, 0);
        chk("timeout/err_cycle", 32'(err_rise_k), 32'd100);

        frm = '{8'hA5, 8'h02, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
                8'h55, 8'h66, 8'h77, 8'h88, 8'h64};
        run_frame("recover", 0, 0, 0);

        // Async reset in the middle of the second data word, FIFO left non-empty.
        model_frame();
        cap_a.delete(); cap_d.delete();
        foreach (frm[k]) q.push_back(frm[k]);
        fin = 0;
        for (int k = 0; k < 200; k++) begin
            tick();
            if (cap_a.size() == 1) begin
                fin = 1;
                break;
            end
        end
        repeat (2) tick();
        chk("rst/reached_data", 32'(fin & prog_active), 32'd1);
        #2 rst_n = 1'b0;
        pend_pop = 0;
        #1 chk_cleared("rst_async");
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("rst/no_pop", 32'(rx_ren), 32'd0);
        end
        q.delete();
        pend_pop = 0;
        rst_n = 1'b1;
        build_frame(32'd2, 2, 0, 4);
        run_frame("after_rst", 0, 0, 0);

        for (int f = 0; f < 30; f++) begin
            kind = $urandom_range(7);
            nw   = $urandom_range(5);
            g    = $urandom_range(3);
            if (kind == 0) begin
                build_frame(32'd4097 + 32'($urandom_range(60000)), 0, 0, g);
                frm.delete(frm.size() - 1);
            end else begin
                build_frame(32'(nw), nw, kind == 1, g);
                if (kind == 2) begin
                    keep = $urandom_range(frm.size() - 1, g + 2);
                    while (frm.size() > keep) frm.delete(frm.size() - 1);
                end
            end
            run_frame("random", 1'($urandom_range(1)), 0, 1'($urandom_range(1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
